// File: rtl/counter_sequencer.sv
// Command-driven master for the up/down counter: LOAD/CLEAR/RAMP over valid/ready,
// steps the counter toward a target and reports done, err and the step count.
module counter_sequencer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic             load_n,
    output logic [WIDTH-1:0] data_load,
    output logic             ce,
    output logic             up_down,
    input  logic [WIDTH-1:0] count_out,
    input  logic             max_count,
    input  logic             zero,
    output logic             done,
    output logic             err,
    output logic [WIDTH:0]   step_count
);

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_RAMP  = 2'b01;
    localparam logic [1:0] OP_CLEAR = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RAMP, S_DONE} state_t;

    state_t           state_q;
    logic [1:0]       op_q;
    logic [WIDTH-1:0] target_q;
    logic [WIDTH-1:0] data_load_q;
    logic             load_n_q;
    logic             up_down_q;
    logic             done_q;
    logic             err_q;
    logic [WIDTH:0]   step_q;
    logic [WIDTH:0]   step_count_q;
    logic             ce_d;

    // The counter flags do not influence sequencing.
    logic unused_flags;
    assign unused_flags = &{1'b0, max_count, zero};

    // Stop stepping once the step register saturates at 2^WIDTH (timeout).
    assign ce_d = (state_q == S_RAMP) && (count_out != target_q) && !step_q[WIDTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            op_q         <= OP_LOAD;
            target_q     <= '0;
            data_load_q  <= '0;
            load_n_q     <= 1'b1;
            up_down_q    <= 1'b0;
            done_q       <= 1'b0;
            err_q        <= 1'b0;
            step_q       <= '0;
            step_count_q <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    done_q <= 1'b0;
                    err_q  <= 1'b0;
                    if (cmd_valid) begin
                        op_q     <= cmd_op;
                        target_q <= cmd_data;
                        case (cmd_op)
                            OP_LOAD: begin
                                data_load_q <= cmd_data;
                                load_n_q    <= 1'b0;
                                state_q     <= S_LOAD;
                            end
                            OP_CLEAR: begin
                                data_load_q <= '0;
                                load_n_q    <= 1'b0;
                                state_q     <= S_LOAD;
                            end
                            OP_RAMP: begin
                                up_down_q <= (cmd_data > count_out);
                                step_q    <= '0;
                                state_q   <= S_RAMP;
                            end
                            default: begin
                                done_q  <= 1'b1;
                                err_q   <= 1'b1;
                                state_q <= S_DONE;
                            end
                        endcase
                    end
                end
                S_LOAD: begin
                    load_n_q <= 1'b1;
                    done_q   <= 1'b1;
                    err_q    <= 1'b0;
                    state_q  <= S_DONE;
                end
                S_RAMP: begin
                    if (ce_d) step_q <= step_q + 1'b1;
                    if (count_out == target_q) begin
                        done_q  <= 1'b1;
                        err_q   <= 1'b0;
                        state_q <= S_DONE;
                    end else if (step_q[WIDTH]) begin
                        done_q  <= 1'b1;
                        err_q   <= 1'b1;
                        state_q <= S_DONE;
                    end
                end
                S_DONE: begin
                    done_q <= 1'b0;
                    err_q  <= 1'b0;
                    if (op_q == OP_RAMP) step_count_q <= step_q;
                    state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign cmd_ready  = (state_q == S_IDLE) && !rst;
    assign load_n     = load_n_q;
    assign data_load  = data_load_q;
    assign ce         = ce_d;
    assign up_down    = up_down_q;
    assign done       = done_q;
    assign err        = err_q;
    assign step_count = step_count_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Directed bench for counter_sequencer with a behavioural up/down counter attached.
module tb_counter_sequencer;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         cnt_rst = 1'b1;
    logic         cmd_valid = 1'b0;
    logic [1:0]   cmd_op = 2'b00;
    logic [W-1:0] cmd_data = '0;
    logic         cmd_ready, load_n, ce, up_down, done, err, max_count, zero;
    logic [W-1:0] data_load, count_out, cnt;
    logic [W:0]   step_count;

    int vecs = 0;
    int errs = 0;
    int ce_total = 0;
    int max_total = 0;
    int wrap_total = 0;

    always #5 clk = ~clk;

    counter_sequencer #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
        .cmd_op(cmd_op), .cmd_data(cmd_data), .load_n(load_n), .data_load(data_load),
        .ce(ce), .up_down(up_down), .count_out(count_out), .max_count(max_count),
        .zero(zero), .done(done), .err(err), .step_count(step_count)
    );

    // Reference counter: load beats count enable; cnt_rst holds it at zero.
    always_ff @(posedge clk) begin
        if (cnt_rst)      cnt <= '0;
        else if (!load_n) cnt <= data_load;
        else if (ce)      cnt <= up_down ? cnt + 1'b1 : cnt - 1'b1;
    end
    assign count_out = cnt;
    assign max_count = &cnt;
    assign zero      = (cnt == '0);

    always @(posedge clk) begin
        if (ce) begin
            ce_total++;
            if ((up_down && cnt == 4'hF) || (!up_down && cnt == 4'h0)) wrap_total++;
        end
        if (max_count) max_total++;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Offer one command and return in the cycle after the accept edge.
    task automatic issue(input logic [1:0] op, input logic [W-1:0] d);
        int n = 0;
        while (!cmd_ready && n < 50) begin tick(); n++; end
        vecs++;
        if (cmd_ready !== 1'b1) begin errs++; $display("FAIL issue_ready got %b exp 1", cmd_ready); end
        cmd_valid = 1'b1; cmd_op = op; cmd_data = d;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic preload(input logic [W-1:0] d);
        issue(2'b00, d);
        tick(); tick();
    endtask

    task automatic test_reset;
        rst = 1'b1; cnt_rst = 1'b1;
        tick(); tick();
        vecs++; if (cmd_ready !== 1'b0) begin errs++; $display("FAIL rst_ready got %b exp 0", cmd_ready); end
        vecs++; if (load_n !== 1'b1) begin errs++; $display("FAIL rst_load_n got %b exp 1", load_n); end
        vecs++; if (ce !== 1'b0) begin errs++; $display("FAIL rst_ce got %b exp 0", ce); end
        vecs++; if (up_down !== 1'b0) begin errs++; $display("FAIL rst_up_down got %b exp 0", up_down); end
        vecs++; if (data_load !== 4'd0) begin errs++; $display("FAIL rst_data_load got %0d exp 0", data_load); end
        vecs++; if ({done, err} !== 2'b00) begin errs++; $display("FAIL rst_done_err got %b exp 00", {done, err}); end
        vecs++; if (step_count !== 5'd0) begin errs++; $display("FAIL rst_step_count got %0d exp 0", step_count); end
        rst = 1'b0; cnt_rst = 1'b0;
        tick();
        vecs++; if (cmd_ready !== 1'b1) begin errs++; $display("FAIL rst_ready_rel got %b exp 1", cmd_ready); end
    endtask

    task automatic test_load;
        issue(2'b00, 4'd9);
        vecs++; if (load_n !== 1'b0) begin errs++; $display("FAIL load_n_low got %b exp 0", load_n); end
        vecs++; if (data_load !== 4'd9) begin errs++; $display("FAIL load_data got %0d exp 9", data_load); end
        vecs++; if (done !== 1'b0) begin errs++; $display("FAIL load_done_early got %b exp 0", done); end
        tick();
        vecs++; if (count_out !== 4'd9) begin errs++; $display("FAIL load_count got %0d exp 9", count_out); end
        vecs++; if ({done, err} !== 2'b10) begin errs++; $display("FAIL load_done got %b exp 10", {done, err}); end
        vecs++; if (load_n !== 1'b1) begin errs++; $display("FAIL load_n_high got %b exp 1", load_n); end
        tick();
        vecs++; if ({cmd_ready, done} !== 2'b10) begin errs++; $display("FAIL load_ready got %b exp 10", {cmd_ready, done}); end
    endtask

    task automatic test_ramp_up;
        int s, m, n;
        preload(4'd3);
        s = ce_total; m = max_total;
        issue(2'b01, 4'd12);
        vecs++; if (up_down !== 1'b1) begin errs++; $display("FAIL up_dir got %b exp 1", up_down); end
        n = 1;
        while (!done && n < 40) begin tick(); n++; end
        vecs++; if (n !== 11) begin errs++; $display("FAIL up_latency got %0d exp 11", n); end
        vecs++; if (count_out !== 4'd12) begin errs++; $display("FAIL up_count got %0d exp 12", count_out); end
        vecs++; if (err !== 1'b0) begin errs++; $display("FAIL up_err got %b exp 0", err); end
        vecs++; if (ce_total - s !== 9) begin errs++; $display("FAIL up_ce_cycles got %0d exp 9", ce_total - s); end
        vecs++; if (max_total - m !== 0) begin errs++; $display("FAIL up_max_seen got %0d exp 0", max_total - m); end
        tick();
        vecs++; if (step_count !== 5'd9) begin errs++; $display("FAIL up_steps got %0d exp 9", step_count); end
    endtask

    task automatic test_ramp_down;
        int s, w, n;
        preload(4'd15);
        s = ce_total; w = wrap_total;
        issue(2'b01, 4'd0);
        vecs++; if (up_down !== 1'b0) begin errs++; $display("FAIL dn_dir got %b exp 0", up_down); end
        n = 1;
        while (!done && n < 40) begin tick(); n++; end
        vecs++; if (n !== 17) begin errs++; $display("FAIL dn_latency got %0d exp 17", n); end
        vecs++; if (zero !== 1'b1) begin errs++; $display("FAIL dn_zero got %b exp 1", zero); end
        vecs++; if (err !== 1'b0) begin errs++; $display("FAIL dn_err got %b exp 0", err); end
        vecs++; if (ce_total - s !== 15) begin errs++; $display("FAIL dn_ce_cycles got %0d exp 15", ce_total - s); end
        vecs++; if (wrap_total - w !== 0) begin errs++; $display("FAIL dn_wrap got %0d exp 0", wrap_total - w); end
        tick();
        vecs++; if (step_count !== 5'd15) begin errs++; $display("FAIL dn_steps got %0d exp 15", step_count); end
    endtask

    task automatic test_ramp_equal_and_reserved;
        int s;
        preload(4'd5);
        s = ce_total;
        issue(2'b01, 4'd5);
        vecs++; if (ce !== 1'b0) begin errs++; $display("FAIL eq_ce got %b exp 0", ce); end
        tick();
        vecs++; if ({done, err} !== 2'b10) begin errs++; $display("FAIL eq_done got %b exp 10", {done, err}); end
        vecs++; if (ce_total - s !== 0) begin errs++; $display("FAIL eq_ce_cycles got %0d exp 0", ce_total - s); end
        tick();
        vecs++; if (step_count !== 5'd0) begin errs++; $display("FAIL eq_steps got %0d exp 0", step_count); end
        issue(2'b11, 4'd7);
        vecs++; if ({done, err} !== 2'b11) begin errs++; $display("FAIL rsv_done got %b exp 11", {done, err}); end
        vecs++; if (load_n !== 1'b1) begin errs++; $display("FAIL rsv_load_n got %b exp 1", load_n); end
        tick();
        vecs++; if (count_out !== 4'd5) begin errs++; $display("FAIL rsv_count got %0d exp 5", count_out); end
        vecs++; if ({cmd_ready, done} !== 2'b10) begin errs++; $display("FAIL rsv_ready got %b exp 10", {cmd_ready, done}); end
    endtask

    task automatic test_timeout;
        int s, n;
        issue(2'b10, 4'd9);
        tick();
        vecs++; if (count_out !== 4'd0) begin errs++; $display("FAIL clr_count got %0d exp 0", count_out); end
        tick();
        cnt_rst = 1'b1;
        s = ce_total;
        issue(2'b01, 4'd10);
        vecs++; if ({up_down, ce} !== 2'b11) begin errs++; $display("FAIL to_start got %b exp 11", {up_down, ce}); end
        n = 1;
        while (!done && n < 40) begin tick(); n++; end
        vecs++; if (n !== 18) begin errs++; $display("FAIL to_latency got %0d exp 18", n); end
        vecs++; if (err !== 1'b1) begin errs++; $display("FAIL to_err got %b exp 1", err); end
        vecs++; if (ce_total - s !== 16) begin errs++; $display("FAIL to_ce_cycles got %0d exp 16", ce_total - s); end
        tick();
        vecs++; if (step_count !== 5'd16) begin errs++; $display("FAIL to_steps got %0d exp 16", step_count); end
        cnt_rst = 1'b0;
    endtask

    task automatic test_reset_mid;
        int n;
        issue(2'b01, 4'd14);
        n = 0;
        while (count_out != 4'd6 && n < 20) begin tick(); n++; end
        vecs++; if (count_out !== 4'd6) begin errs++; $display("FAIL mid_reach got %0d exp 6", count_out); end
        rst = 1'b1;
        tick();
        vecs++; if ({ce, done, cmd_ready} !== 3'b000) begin errs++; $display("FAIL mid_abort got %b exp 000", {ce, done, cmd_ready}); end
        vecs++; if (count_out !== 4'd7) begin errs++; $display("FAIL mid_count got %0d exp 7", count_out); end
        tick();
        rst = 1'b0;
        tick();
        vecs++; if ({cmd_ready, done} !== 2'b10) begin errs++; $display("FAIL mid_idle got %b exp 10", {cmd_ready, done}); end
        vecs++; if (count_out !== 4'd7) begin errs++; $display("FAIL mid_hold got %0d exp 7", count_out); end
        issue(2'b10, 4'd5);
        tick();
        vecs++; if ({done, count_out} !== {1'b1, 4'd0}) begin errs++; $display("FAIL mid_clear got %b exp 10000", {done, count_out}); end
        tick();
    endtask

    task automatic test_back_to_back;
        int n;
        cmd_valid = 1'b1; cmd_op = 2'b00; cmd_data = 4'd2;
        @(posedge clk);
        #1;
        cmd_op = 2'b01; cmd_data = 4'd8;
        vecs++; if ({cmd_ready, load_n} !== 2'b00) begin errs++; $display("FAIL b2b_n1 got %b exp 00", {cmd_ready, load_n}); end
        tick();
        vecs++; if ({cmd_ready, done, count_out} !== {2'b01, 4'd2}) begin errs++; $display("FAIL b2b_n2 got %b exp 010010", {cmd_ready, done, count_out}); end
        tick();
        vecs++; if (cmd_ready !== 1'b1) begin errs++; $display("FAIL b2b_n3 got %b exp 1", cmd_ready); end
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        vecs++; if ({up_down, ce} !== 2'b11) begin errs++; $display("FAIL b2b_ramp got %b exp 11", {up_down, ce}); end
        n = 1;
        while (!done && n < 20) begin tick(); n++; end
        vecs++; if ({done, count_out} !== {1'b1, 4'd8}) begin errs++; $display("FAIL b2b_done got %b exp 11000", {done, count_out}); end
        tick();
        vecs++; if (step_count !== 5'd6) begin errs++; $display("FAIL b2b_steps got %0d exp 6", step_count); end
    endtask

    initial begin
        test_reset();
        test_load();
        test_ramp_up();
        test_ramp_down();
        test_ramp_equal_and_reserved();
        test_timeout();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
